// File: rtl/serial_word_assembler.sv
// serial_word_assembler: collects BIT_WIDTH serial bits into a parallel word and
// presents it on a valid/ready port backed by a one-word holding register.
// Optional build macro: LSB_FIRST_EN selects LSB-first wire order (default MSB-first).
module serial_word_assembler #(
    parameter int BIT_WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_start,
    output logic [BIT_WIDTH-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CW = $clog2(BIT_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]   sh_q, sh_d;
    logic [BIT_WIDTH-1:0]   word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    // frame_start wipes the partial word before the current bit is applied
    logic [CW-1:0]          base_cnt;
    logic [BIT_WIDTH-1:0]   base_sh;
    logic [BIT_WIDTH-1:0]   shifted;
    logic                   complete;

    assign base_cnt = frame_start ? '0 : cnt_q;
    assign base_sh  = frame_start ? '0 : sh_q;

`ifdef LSB_FIRST_EN
    assign shifted = {bit_in, base_sh[BIT_WIDTH-1:1]};
`else
    assign shifted = {base_sh[BIT_WIDTH-2:0], bit_in};
`endif

    // Next-state: bit assembly, completion, output handshake and overrun detection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovr_d    = 1'b0;
        complete = 1'b0;

        if (frame_start) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
        end

        if (bit_valid) begin
            if (base_cnt == LAST) begin
                complete = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
                sh_d     = '0;
            end else begin
                state_d  = SHIFT;
                cnt_d    = base_cnt + CW'(1);
                sh_d     = shifted;
            end
        end

        // A word that completes while the held word is stalled is dropped
        if (complete) begin
            if (!valid_q || word_ready) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler (BIT_WIDTH=28): table of words plus hand sequences
// for latency, backpressure/overrun, simultaneous transfer, abort and async reset.
module tb_serial_word_assembler;

    localparam int W = 28;

    logic         clk, rst_n, bit_in, bit_valid, frame_start, word_ready;
    logic [W-1:0] word_out;
    logic         word_valid, busy, overrun;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    serial_word_assembler #(.BIT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] stream;   // stream bit k = stream[W-1-k]
        logic [W-1:0] exp_msb;  // expected word for MSB-first placement
        bit           gap;      // idle cycle between bits
    } vec_t;

    // Expected word for the wire order this build uses
    function automatic logic [W-1:0] fx(input logic [W-1:0] v);
`ifdef LSB_FIRST_EN
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] s, input int lo, input int hi, input bit gap);
        for (int k = lo; k <= hi; k++) begin
            drive_bit(s[W-1-k]);
            if (gap && k < hi) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && word_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(word_out), 64'hDEAD);
            end else if (word_ready) begin
                chk("sb_word", 64'(word_out), 64'(sb.pop_front()));
            end
        end
    end

    vec_t vt[6];

    initial begin
        vt[0] = '{28'hA5C3F01, 28'hA5C3F01, 1'b0};
        vt[1] = '{28'h8000000, 28'h8000000, 1'b0};
        vt[2] = '{28'h0000001, 28'h0000001, 1'b1};
        vt[3] = '{28'hFFFFFFF, 28'hFFFFFFF, 1'b0};
        vt[4] = '{28'h5555555, 28'h5555555, 1'b1};
        vt[5] = '{28'h0000000, 28'h0000000, 1'b0};

        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; word_ready = 1'b1;
        #1;
        chk("rst_word_out", 64'(word_out), 0);
        chk("rst_word_valid", 64'(word_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_overrun", 64'(overrun), 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic: latency of one edge, valid for exactly one cycle
        send_bits(28'hA5C3F01, 0, 26, 1'b0);
        chk("basic_busy_mid", 64'(busy), 1);
        sb.push_back(fx(28'hA5C3F01));
        send_bits(28'hA5C3F01, 27, 27, 1'b0);
        chk("basic_valid", 64'(word_valid), 1);
        chk("basic_word", 64'(word_out), 64'(fx(28'hA5C3F01)));
        chk("basic_busy_done", 64'(busy), 0);
        @(posedge clk); #1;
        chk("basic_valid_drop", 64'(word_valid), 0);

        // Table of words, some with idle gaps between bits
        for (int i = 0; i < 6; i++) begin
            sb.push_back(fx(vt[i].exp_msb));
            send_bits(vt[i].stream, 0, W-1, vt[i].gap);
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure and overrun
        word_ready = 1'b0;
        sb.push_back(fx(28'h1234567));
        send_bits(28'h1234567, 0, W-1, 1'b0);
        send_bits(28'h7654321, 0, W-2, 1'b0);
        chk("bp_hold_word", 64'(word_out), 64'(fx(28'h1234567)));
        chk("bp_no_ovr_yet", 64'(overrun), 0);
        send_bits(28'h7654321, W-1, W-1, 1'b0);
        chk("bp_overrun", 64'(overrun), 1);
        chk("bp_keep_word", 64'(word_out), 64'(fx(28'h1234567)));
        chk("bp_keep_valid", 64'(word_valid), 1);
        @(posedge clk); #1;
        chk("bp_overrun_pulse", 64'(overrun), 0);
        word_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", 64'(word_valid), 0);

        // Transfer and completion on the same edge
        word_ready = 1'b0;
        sb.push_back(fx(28'h0C0FFEE));
        send_bits(28'h0C0FFEE, 0, W-1, 1'b0);
        send_bits(28'hBADF00D, 0, W-2, 1'b0);
        word_ready = 1'b1;
        sb.push_back(fx(28'hBADF00D));
        send_bits(28'hBADF00D, W-1, W-1, 1'b0);
        chk("simul_valid", 64'(word_valid), 1);
        chk("simul_word", 64'(word_out), 64'(fx(28'hBADF00D)));
        chk("simul_overrun", 64'(overrun), 0);
        @(posedge clk); #1;
        chk("simul_drain", 64'(word_valid), 0);

        // Abort with frame_start carrying bit 0 of the new word
        drive_bit(1'b1);
        chk("abort_busy_b1", 64'(busy), 1);
        send_bits(28'hFFFFFFF, 1, 9, 1'b0);
        frame_start = 1'b1;
        drive_bit(1'b0);
        frame_start = 1'b0;
        chk("abort_busy_restart", 64'(busy), 1);
        chk("abort_no_word", 64'(word_valid), 0);
        send_bits(28'h0FFFFFF, 1, W-2, 1'b0);
        chk("abort_busy_before", 64'(busy), 1);
        sb.push_back(fx(28'h0FFFFFF));
        send_bits(28'h0FFFFFF, W-1, W-1, 1'b0);
        chk("abort_busy_after", 64'(busy), 0);
        chk("abort_word", 64'(word_out), 64'(fx(28'h0FFFFFF)));
        @(posedge clk); #1;

        // Asynchronous reset mid-word with a held word
        word_ready = 1'b0;
        sb.push_back(fx(28'h3333333));
        send_bits(28'h3333333, 0, W-1, 1'b0);
        send_bits(28'hFFFFFFF, 0, 4, 1'b0);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_word_out", 64'(word_out), 0);
        chk("arst_word_valid", 64'(word_valid), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_overrun", 64'(overrun), 0);
        #3 rst_n = 1'b1;
        word_ready = 1'b1;
        @(posedge clk); #1;
        sb.push_back(fx(28'h9E3779B));
        send_bits(28'h9E3779B, 0, W-1, 1'b0);
        chk("arst_fresh_word", 64'(word_out), 64'(fx(28'h9E3779B)));

        // Bounded drain of anything still expected
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("sb_empty", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
